// File: rtl/sys_ctrl_pkg.sv
// Shared constants and state encoding for the sys_ctrl command sequencer.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR      = 8'hAA;
  localparam logic [7:0] CMD_RD      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;

  localparam int unsigned OPA_ADDR = 0;
  localparam int unsigned OPB_ADDR = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StAluA,
    StAluB,
    StAluFun,
    StAluWait,
    StTxRd,
    StTxLsb,
    StTxMsb
  } state_e;

endpackage

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes UART command frames into register-file and ALU
// strobes, and pushes response bytes into the TX FIFO.
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned FUN_WIDTH     = 4,
  parameter int unsigned ALU_OUT_WIDTH = 16,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     FIFO_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_EN,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD
);

  localparam int unsigned CntWidth = $clog2(TIMEOUT + 1);

  state_e                   state_q, state_d;
  logic [CntWidth-1:0]      cnt_q, cnt_d;
  logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                     wr_en_q, wr_en_d;
  logic                     rd_en_q, rd_en_d;
  logic                     alu_en_q, alu_en_d;
  logic                     clk_en_q, clk_en_d;
  logic                     tx_vld_q, tx_vld_d;
  logic                     timeout;

  // Last waiting cycle: the wait states have then lasted TIMEOUT cycles.
  assign timeout = (cnt_q == CntWidth'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    alu_fun_d = alu_fun_q;
    clk_en_d  = clk_en_q;
    tx_data_d = tx_data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    alu_en_d  = 1'b0;
    tx_vld_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WR))           state_d = StWrAddr;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_RD))      state_d = StRdAddr;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP))  state_d = StAluA;
          else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOP)) state_d = StAluFun;
        end
      end
      StWrAddr: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d = StWrData;
      end
      StWrData: if (RX_D_VLD) begin
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = StIdle;
      end
      StRdAddr: if (RX_D_VLD) begin
        addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
        rd_en_d = 1'b1;
        cnt_d   = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (RdData_Valid) begin
          result_d = ALU_OUT_WIDTH'(RdData);
          state_d  = StTxRd;
        end else if (timeout) begin
          result_d = ALU_OUT_WIDTH'(ERR_BYTE);
          state_d  = StTxRd;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StAluA: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPA_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = StAluB;
      end
      StAluB: if (RX_D_VLD) begin
        addr_d    = ADDR_WIDTH'(OPB_ADDR);
        wr_data_d = RX_P_DATA;
        wr_en_d   = 1'b1;
        state_d   = StAluFun;
      end
      StAluFun: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
        alu_en_d  = 1'b1;
        clk_en_d  = 1'b1;
        cnt_d     = '0;
        state_d   = StAluWait;
      end
      StAluWait: begin
        if (OUT_Valid) begin
          result_d = ALU_OUT;
          clk_en_d = 1'b0;
          state_d  = StTxLsb;
        end else if (timeout) begin
          // The error byte reuses the single-byte read response path.
          result_d = ALU_OUT_WIDTH'(ERR_BYTE);
          clk_en_d = 1'b0;
          state_d  = StTxRd;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      StTxRd: if (!FIFO_FULL) begin
        tx_data_d = result_q[DATA_WIDTH-1:0];
        tx_vld_d  = 1'b1;
        state_d   = StIdle;
      end
      StTxLsb: if (!FIFO_FULL) begin
        tx_data_d = result_q[DATA_WIDTH-1:0];
        tx_vld_d  = 1'b1;
        state_d   = StTxMsb;
      end
      StTxMsb: if (!FIFO_FULL) begin
        tx_data_d = result_q[DATA_WIDTH +: DATA_WIDTH];
        tx_vld_d  = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      result_q  <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      alu_fun_q <= '0;
      tx_data_q <= '0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      alu_en_q  <= 1'b0;
      clk_en_q  <= 1'b0;
      tx_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      alu_fun_q <= alu_fun_d;
      tx_data_q <= tx_data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      alu_en_q  <= alu_en_d;
      clk_en_q  <= clk_en_d;
      tx_vld_q  <= tx_vld_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule

// File: doc/sys_ctrl.md
Name: sys_ctrl

Overview:
- Command sequencer between the UART receive path and the system resources (register file, ALU, TX FIFO).
- Consumes validated bytes from the UART receiver and decodes multi-byte command frames.
- Issues register-file read/write strobes and ALU enable/function with clock-gate enable.
- Pushes response bytes into the TX FIFO write port, honouring FIFO full.

Parameters:
DATA_WIDTH, 8, byte width of RX/TX data and register data
ADDR_WIDTH, 4, register-file address width
FUN_WIDTH, 4, ALU function code width
ALU_OUT_WIDTH, 16, ALU result width (two response bytes)
TIMEOUT, 255, max cycles to wait for RdData_Valid / OUT_Valid

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD
RX_D_VLD  in  1  one-cycle pulse per error-free frame; frames with parity/stop errors never pulse
RdData  in  DATA_WIDTH  register-file read data
RdData_Valid  in  1  read data valid pulse
ALU_OUT  in  ALU_OUT_WIDTH  ALU result
OUT_Valid  in  1  ALU result valid pulse
FIFO_FULL  in  1  TX FIFO full
WrEn  out  1  register write strobe
RdEn  out  1  register read strobe
Address  out  ADDR_WIDTH  register address
WrData  out  DATA_WIDTH  register write data
ALU_EN  out  1  ALU start strobe
ALU_FUN  out  FUN_WIDTH  ALU function
CLK_EN  out  1  ALU clock-gate enable
TX_P_DATA  out  DATA_WIDTH  byte to TX FIFO
TX_D_VLD  out  1  TX FIFO write strobe

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset: all outputs 0; state IDLE; result and timeout counter 0.
- Outputs are registered. WrEn, RdEn, ALU_EN and TX_D_VLD are single-cycle pulses asserted the cycle after the triggering event.
- Command codes:
  - 0xAA = write: addr, data.
  - 0xBB = read: addr.
  - 0xCC = ALU with operands: A, B, fun.
  - 0xDD = ALU without operands: fun.
- IDLE: on RX_D_VLD, decode the byte. 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_A, 0xDD->ALU_FUN. Any other code is ignored; stay IDLE.
- WR_ADDR: on byte, latch Address=byte[ADDR_WIDTH-1:0] -> WR_DATA.
- WR_DATA: on byte, WrData=byte, WrEn pulse -> IDLE. No response byte is sent.
- RD_ADDR: on byte, Address=byte, RdEn pulse -> RD_WAIT.
- RD_WAIT: on RdData_Valid, latch RdData -> TX_RD.
- ALU_A: on byte, Address=0, WrData=byte, WrEn pulse -> ALU_B.
- ALU_B: same with Address=1 -> ALU_FUN.
- ALU_FUN: on byte, ALU_FUN=byte[FUN_WIDTH-1:0], ALU_EN pulse, CLK_EN=1 -> ALU_WAIT.
- ALU_WAIT: CLK_EN held 1. On OUT_Valid, latch ALU_OUT -> TX_LSB; CLK_EN=0 from the next cycle.
- TX_RD / TX_LSB / TX_MSB: while FIFO_FULL=1, hold state with TX_D_VLD=0. When FIFO_FULL=0, drive TX_P_DATA and pulse TX_D_VLD once, then advance:
  - TX_RD pushes the read byte -> IDLE.
  - TX_LSB pushes result[7:0] -> TX_MSB.
  - TX_MSB pushes result[15:8] -> IDLE.
- Timeout:
  - Counter clears on entry to RD_WAIT/ALU_WAIT and increments each cycle there.
  - Reaching TIMEOUT with no valid: load ERR_BYTE 0xEE as the response, go TX_RD, drop CLK_EN.
  - A valid pulse in the same cycle as the timeout wins over the timeout.
- RX_D_VLD while in RD_WAIT, ALU_WAIT or any TX state: the byte is dropped, with no effect.
- Simultaneous RdData_Valid and OUT_Valid: only the one matching the current wait state is used.
- Reset mid-command: return to IDLE immediately. Any pulse in flight is cleared and the partial frame is discarded.

Decomposition:
- Package sys_ctrl_pkg holds:
  - command codes CMD_WR=0xAA, CMD_RD=0xBB, CMD_ALU_OP=0xCC, CMD_ALU_NOP=0xDD;
  - ERR_BYTE=0xEE;
  - operand addresses OPA_ADDR=0, OPB_ADDR=1;
  - the state enumeration.
- Single module; the timeout counter and TX push logic are inline. No sub-module is warranted.

Test Plan:
- Write: RX bytes 0xAA, 0x05, 0x3C -> exactly one WrEn pulse with Address=5, WrData=0x3C; no TX_D_VLD.
- Read: 0xBB, 0x05; model returns RdData=0x3C two cycles after RdEn -> RdEn with Address=5, then one TX_D_VLD with TX_P_DATA=0x3C.
- ALU with operands: 0xCC, 0x12, 0x34, 0x00; model returns ALU_OUT=0x0046 -> WrEn at addr 0 (0x12) then addr 1 (0x34); ALU_EN with ALU_FUN=0; CLK_EN high until OUT_Valid; TX bytes 0x46 then 0x00.
- FIFO backpressure: 0xDD, 0x01 with FIFO_FULL=1 for 10 cycles after OUT_Valid, ALU_OUT=0xABCD -> no TX_D_VLD while full; then 0xCD, 0xAB in order, each pulsed once.
- Timeout: 0xBB, 0x03 with RdData_Valid never asserted -> after 255 cycles one TX_D_VLD with 0xEE, return IDLE. Unknown code 0x55 in IDLE -> no outputs.
- Reset mid-frame: 0xAA, 0x02, then rst_n low for 2 cycles, then 0x3C -> no WrEn; 0x3C is treated as an unknown command and ignored.
